// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
// master: pipeline datapath (drives hazard info, receives controls)
// slave:  hazard controller (receives hazard info, drives controls)
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] rs_num_ID, rt_num_ID, rd_num_EX;
  logic uses_rt_ID, reg_write_enable_EX, mem_or_reg_EX;
  logic redirect_MEM, mem_req_MEM, mem_ready, halt_req;
  logic pc_we, halted, mem_timeout;
  logic stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output rs_num_ID, rt_num_ID, uses_rt_ID, rd_num_EX, reg_write_enable_EX, mem_or_reg_EX,
           redirect_MEM, mem_req_MEM, mem_ready, halt_req,
    input  pc_we, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted, mem_timeout, stall_count
  );
  modport slave (
    input  rs_num_ID, rt_num_ID, uses_rt_ID, rd_num_EX, reg_write_enable_EX, mem_or_reg_EX,
           redirect_MEM, mem_req_MEM, mem_ready, halt_req,
    output pc_we, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the IF/ID..MEM/WB buffers and PC
// clk, rst_b (async active-low); bus: hazard inputs in, pc_we/stall/flush/halted/mem_timeout/stall_count out
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_b,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  logic [1:0] state;
  logic [WW-1:0] wait_cnt, wait_inc;
  logic [2:0] drain_cnt;
  logic [CNT_W-1:0] stall_count;
  logic mem_timeout;
  logic active, freeze, hazard, redir, lu, hlt, drain_out, halt_s, pc_we_i;
  always_comb begin
    active    = state == RUN || state == MEM_WAIT;
    // once waiting, only mem_ready releases the freeze; DRAIN still honours a new wait
    freeze    = (state == MEM_WAIT) ? ~bus.mem_ready
              : (state == RUN || state == DRAIN) & bus.mem_req_MEM & ~bus.mem_ready;
    hazard    = bus.reg_write_enable_EX & bus.mem_or_reg_EX & (bus.rd_num_EX != 5'd0) &
                (bus.rd_num_EX == bus.rs_num_ID | (bus.uses_rt_ID & bus.rd_num_EX == bus.rt_num_ID));
    redir     = active & ~freeze & bus.redirect_MEM;
    lu        = active & ~freeze & ~bus.redirect_MEM & hazard;
    hlt       = active & ~freeze & ~bus.redirect_MEM & ~hazard & bus.halt_req;
    drain_out = state == DRAIN & ~freeze;
    halt_s    = state == HALTED;
    pc_we_i   = ~(freeze | lu | hlt | drain_out | halt_s);
    // the cycle that enters MEM_WAIT already counts as wait cycle one
    wait_inc  = ((state == MEM_WAIT) ? wait_cnt : WW'(0)) + WW'(1);
  end
  assign bus.pc_we        = rst_b & pc_we_i;
  assign bus.stall_IF_ID  = rst_b & (freeze | lu | halt_s);
  assign bus.stall_ID_EX  = rst_b & (freeze | halt_s);
  assign bus.stall_EX_MEM = rst_b & (freeze | halt_s);
  assign bus.stall_MEM_WB = rst_b & halt_s;
  assign bus.flush_IF_ID  = rst_b & (redir | hlt | drain_out);
  assign bus.flush_ID_EX  = rst_b & (redir | lu);
  assign bus.flush_EX_MEM = rst_b & redir;
  assign bus.flush_MEM_WB = rst_b & freeze;
  assign bus.halted       = rst_b & halt_s;
  assign bus.mem_timeout  = mem_timeout;
  assign bus.stall_count  = stall_count;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (active & ~pc_we_i & ~&stall_count) stall_count <= stall_count + 1'b1;
      if (active & freeze) begin
        if (wait_inc >= WW'(MEM_TIMEOUT)) begin
          state       <= HALTED;
          mem_timeout <= 1'b1;
        end else begin
          state    <= MEM_WAIT;
          wait_cnt <= wait_inc;
        end
      end else if (hlt) begin
        state     <= DRAIN;
        drain_cnt <= '0;
        wait_cnt  <= '0;
      end else if (state == MEM_WAIT) begin
        state    <= RUN;
        wait_cnt <= '0;
      end else if (drain_out) begin
        if (drain_cnt == 3'(DRAIN_CYCLES - 1)) state <= HALTED;
        else drain_cnt <= drain_cnt + 3'd1;
      end
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It detects load-use hazards, freezes the pipeline while a multi-cycle data-memory access is outstanding, and squashes wrong-path instructions on a branch or jump redirect resolved in MEM. It also sequences a halt drain and keeps a saturating stall-cycle counter. It drives the buffers' stall (write-enable inverse) and flush (load-zero bubble) inputs.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before a fatal timeout
DRAIN_CYCLES, 3, cycles in DRAIN before HALTED (1..7)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
rs_num_ID  in  5  rs field of instruction in ID
rt_num_ID  in  5  rt field of instruction in ID
uses_rt_ID  in  1  ID instruction reads rt as a source
rd_num_EX  in  5  destination register of EX instruction
reg_write_enable_EX  in  1  EX instruction writes the register file
mem_or_reg_EX  in  1  1 = EX instruction's writeback comes from memory (load)
redirect_MEM  in  1  taken branch / jump / jr resolved in MEM
mem_req_MEM  in  1  MEM instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  halt instruction reached MEM
pc_we  out  1  PC write enable
stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out  1 each  hold buffer contents
flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  load bubble (all zero) into buffer
halted  out  1  core halted
mem_timeout  out  1  sticky memory timeout flag
stall_count  out  CNT_W  cycles with pc_we=0 in RUN/MEM_WAIT, saturating

Behaviour:
- Reset (rst_b=0, async): state=RUN, wait_cnt=0, drain_cnt=0, stall_count=0, mem_timeout=0. While rst_b=0, outputs are forced to pc_we=0, all stall=0, all flush=0, halted=0.
- Outputs are combinational from state and inputs. Default in RUN: pc_we=1, all stall/flush=0.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Priority in RUN: mem wait > redirect > load-use > halt_req.
- Mem wait: mem_req_MEM & ~mem_ready.
  - Outputs: pc_we=0; stall_IF_ID, stall_ID_EX, stall_EX_MEM=1; flush_MEM_WB=1.
  - Next state MEM_WAIT, wait_cnt<=1.
- MEM_WAIT, mem_ready=0: same freeze outputs; wait_cnt++.
  - When wait_cnt==MEM_TIMEOUT: set mem_timeout and go to HALTED.
- MEM_WAIT, mem_ready=1: outputs evaluated by the RUN rules with the mem-wait term false. Next state RUN, wait_cnt<=0.
- Redirect (redirect_MEM):
  - Outputs: pc_we=1; flush_IF_ID, flush_ID_EX, flush_EX_MEM=1.
  - Lasts one cycle.
  - Overrides load-use and halt_req in the same cycle, because the younger instructions are squashed.
- Load-use: reg_write_enable_EX & mem_or_reg_EX & rd_num_EX!=0 & (rd_num_EX==rs_num_ID | (uses_rt_ID & rd_num_EX==rt_num_ID)).
  - Outputs: pc_we=0, stall_IF_ID=1, flush_ID_EX=1.
  - Lasts exactly one cycle, since the load advances to MEM.
- halt_req with no higher-priority event: pc_we=0, flush_IF_ID=1. Next state DRAIN, drain_cnt<=0.
- DRAIN: pc_we=0, flush_IF_ID=1; drain_cnt++. Redirect/load-use/halt_req are ignored; mem wait still freezes and does not count. After DRAIN_CYCLES counted cycles, go to HALTED.
- HALTED: halted=1, pc_we=0, all four stall=1, flushes=0. Exit only by reset.
- stall_count: increments on each clk edge where the state is RUN or MEM_WAIT, rst_b=1 and pc_we=0. It holds at 2^CNT_W-1.
- A stall and a flush are never both asserted for the same buffer.

Test Plan:
- Load-use: lw $8 in EX (rd_num_EX=8, reg_write_enable_EX=1, mem_or_reg_EX=1), rs_num_ID=8 → one cycle of pc_we=0, stall_IF_ID=1, flush_ID_EX=1; next cycle defaults; stall_count=1. Same case with rd_num_EX=0 → no stall.
- rt hazard: rt_num_ID=9 with uses_rt_ID=0 vs 1, rd_num_EX=9 load → stall only when uses_rt_ID=1.
- Memory wait: mem_req_MEM=1, mem_ready low for 3 cycles then high → 3 freeze cycles (flush_MEM_WB=1), release on the 4th; stall_count=3. Repeat with mem_ready never high and MEM_TIMEOUT=4 → mem_timeout=1, halted=1 after 4 wait cycles.
- Redirect with simultaneous load-use and halt_req → only flush_IF_ID/ID_EX/EX_MEM=1, pc_we=1, state stays RUN.
- Halt: halt_req pulse → DRAIN for 3 cycles (flush_IF_ID=1), then halted=1 and all stalls=1 indefinitely. Deassert rst_b mid-DRAIN → all outputs reset immediately; after release, RUN with pc_we=1.
- Saturation: CNT_W=2, 5 load-use stall cycles → stall_count=3.
